// File: rtl/gigatron_pad.sv
// Serial NES/Famicom gamepad poller: latches, clocks and deserialises the 8 button
// bits into the byte consumed by the core's i_in port (0 = pressed, 8'hFF = idle).
module gigatron_pad #(
    parameter int unsigned HALF        = 150,
    parameter int unsigned POLL_PERIOD = 416667
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_poll,
    input  logic       i_pad_data,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    output logic [7:0] o_in,
    output logic       o_valid,
    output logic       o_busy
);

    localparam int unsigned PW = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam int unsigned CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam bit          AUTO_EN = (POLL_PERIOD != 0);

    typedef enum logic [2:0] {
        IDLE, LATCH, SETTLE, LOW, HIGH, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    in_d;
    logic [CW-1:0] poll_cnt_q;
    logic [1:0]    sync_q;
    logic          data_s;
    logic          trigger_c;
    logic          last_c;

    assign data_s    = sync_q[1];
    assign trigger_c = i_poll | (AUTO_EN && (poll_cnt_q == CW'(POLL_PERIOD - 1)));
    assign last_c    = (phase_q == '0);

    // Two-flop synchroniser for the asynchronous pad data line
    always_ff @(posedge i_clock) begin
        if (i_reset) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], i_pad_data};
    end

    // Free-running auto-poll counter; wraps regardless of scan state
    always_ff @(posedge i_clock) begin
        if (i_reset || !AUTO_EN)                    poll_cnt_q <= '0;
        else if (poll_cnt_q == CW'(POLL_PERIOD - 1)) poll_cnt_q <= '0;
        else                                         poll_cnt_q <= poll_cnt_q + CW'(1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            bits_q      <= '0;
            shift_q     <= '0;
            o_in        <= 8'hFF;
            o_pad_latch <= 1'b0;
            o_pad_clk   <= 1'b1;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bits_q      <= bits_d;
            shift_q     <= shift_d;
            o_in        <= in_d;
            o_pad_latch <= (state_d == LATCH);
            o_pad_clk   <= (state_d != LOW);
            o_valid     <= (state_d == DONE);
            o_busy      <= (state_d != IDLE);
        end
    end

    // Next-state logic; phase counts down and is reloaded on every state entry
    always_comb begin
        state_d = state_q;
        phase_d = last_c ? '0 : phase_q - PW'(1);
        bits_d  = bits_q;
        shift_d = shift_q;
        in_d    = o_in;
        case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    state_d = LATCH;
                    phase_d = PW'(2 * HALF - 1);
                    bits_d  = '0;
                end
            end
            LATCH: begin
                if (last_c) begin
                    state_d = SETTLE;
                    phase_d = PW'(HALF - 1);
                end
            end
            SETTLE: begin
                if (last_c) begin
                    shift_d = {shift_q[6:0], data_s};
                    bits_d  = 3'd1;
                    state_d = LOW;
                    phase_d = PW'(HALF - 1);
                end
            end
            LOW: begin
                if (last_c) begin
                    state_d = HIGH;
                    phase_d = PW'(HALF - 1);
                end
            end
            HIGH: begin
                if (last_c) begin
                    shift_d = {shift_q[6:0], data_s};
                    bits_d  = bits_q + 3'd1;
                    if (bits_q == 3'd7) begin
                        in_d    = {shift_q[6:0], data_s};
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        phase_d = PW'(HALF - 1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gigatron_pad.sv
// Scoreboard bench for gigatron_pad: a pad model feeds button bytes, expected bytes and
// o_valid cycles are queued at poll time and checked by an independent monitor.
module tb_gigatron_pad;

    localparam int unsigned HALF = 4;
    localparam int          LAT  = 17 * HALF;

    logic       clk = 1'b0;
    logic       rst, poll, pad_data;
    logic       latch, pclk, valid, busy;
    logic [7:0] in_b;
    logic       latch1, pclk1, valid1, busy1;
    logic [7:0] in1;

    always #5 clk = ~clk;

    gigatron_pad #(.HALF(HALF), .POLL_PERIOD(0)) dut (
        .i_clock(clk), .i_reset(rst), .i_poll(poll), .i_pad_data(pad_data),
        .o_pad_latch(latch), .o_pad_clk(pclk), .o_in(in_b), .o_valid(valid), .o_busy(busy)
    );

    gigatron_pad #(.HALF(HALF), .POLL_PERIOD(200)) dut_auto (
        .i_clock(clk), .i_reset(rst), .i_poll(1'b0), .i_pad_data(1'b1),
        .o_pad_latch(latch1), .o_pad_clk(pclk1), .o_in(in1), .o_valid(valid1), .o_busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: parallel load while latched, shift on each rising pad clock
    logic [7:0] buttons = 8'hFF;
    logic [7:0] pad_sr  = 8'hFF;
    logic       pclk_prev = 1'b1;
    always @(posedge clk) begin
        pclk_prev <= pclk;
        if (latch)                  pad_sr <= buttons;
        else if (pclk && !pclk_prev) pad_sr <= {pad_sr[6:0], 1'b1};
    end
    assign pad_data = pad_sr[7];

    typedef struct {
        logic [7:0] data;
        int         vcyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every o_valid and checks per-scan pulse shape
    int   lows = 0, lat_cyc = 0, extra = 0;
    int   last_auto = -1, n_auto = 0;
    logic pclk_last = 1'b1;
    exp_t e;
    always @(negedge clk) begin
        if (!busy) begin
            lows    = 0;
            lat_cyc = 0;
        end else begin
            if (pclk_last && !pclk) lows++;
            if (latch) lat_cyc++;
        end
        if (valid) begin
            if (q.size() == 0) extra++;
            else begin
                e = q.pop_front();
                chk("in_byte", in_b, e.data);
                chk("valid_cycle", cyc, e.vcyc);
                chk("clk_low_pulses", lows, 7);
                chk("latch_cycles", lat_cyc, 2 * HALF);
            end
        end
        if (rst) last_auto = -1;
        else if (valid1) begin
            if (last_auto >= 0) begin
                chk("auto_period", cyc - last_auto, 200);
                n_auto++;
            end
            chk("auto_in", in1, 8'hFF);
            last_auto = cyc;
        end
        pclk_last = pclk;
    end

    task automatic do_poll(input logic [7:0] exp, input bit accept, output int k);
        @(posedge clk);
        #1 poll = 1'b1;
        k = cyc + 1;
        if (accept) q.push_back('{exp, k + LAT});
        @(posedge clk);
        #1 poll = 1'b0;
    endtask

    task automatic wait_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done_in_budget", (n < 400), 1);
    endtask

    task automatic scan(input logic [7:0] b);
        int k;
        buttons = b;
        do_poll(b, 1'b1, k);
        wait_idle();
    endtask

    initial begin
        int k, act;
        rst  = 1'b1;
        poll = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in", in_b, 8'hFF);
        chk("rst_pclk", pclk, 1);
        chk("rst_latch", latch, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);

        act = 0;
        repeat (500) begin
            @(negedge clk);
            if (latch || !pclk || valid || busy) act++;
        end
        chk("idle_activity", act, 0);

        // A pressed, with latch and pad-clock phase timing
        buttons = 8'h7F;
        do_poll(8'h7F, 1'b1, k);
        wait_neg(k);          chk("latch_start", latch, 1);
        wait_neg(k + 7);      chk("latch_end", latch, 1);
        wait_neg(k + 8);      chk("latch_off", latch, 0);
        chk("settle_pclk", pclk, 1);
        wait_neg(k + 12);     chk("first_low", pclk, 0);
        wait_neg(k + 16);     chk("first_high", pclk, 1);
        wait_idle();

        scan(8'hF6);
        scan(8'hFF);

        // Polls while busy are dropped; poll in DONE dropped, the next cycle accepted
        buttons = 8'hF6;
        do_poll(8'hF6, 1'b1, k);
        for (int i = 0; i < 6; i++) begin
            int kk;
            repeat (8) @(posedge clk);
            do_poll(8'h00, 1'b0, kk);
        end
        wait_neg(k + 68);
        chk("done_valid", valid, 1);
        poll = 1'b1;
        q.push_back('{8'hF6, k + 70 + LAT});
        @(posedge clk);
        @(posedge clk);
        #1 poll = 1'b0;
        wait_idle();

        // Reset mid-scan aborts without writing o_in or pulsing o_valid
        buttons = 8'h7F;
        do_poll(8'h7F, 1'b1, k);
        wait_neg(k + 29);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in", in_b, 8'hFF);
        chk("abort_latch", latch, 0);
        chk("abort_pclk", pclk, 1);
        chk("abort_busy", busy, 0);
        repeat (100) @(negedge clk);
        scan(8'h7F);

        repeat (450) @(negedge clk);
        chk("unexpected_valids", extra, 0);
        chk("auto_periods_seen", (n_auto >= 3), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
